// File: rtl/fx3_slave_fifo_rd_engine.sv
// FX3 slave-FIFO read engine: sequences SLCS/SLOE/SLRD bursts from one socket and
// captures DQ after the read latency into a valid-qualified word stream.
module fx3_slave_fifo_rd_engine #(
   parameter int         DATA_W    = 32,
   parameter int         BURST_LEN = 256,
   parameter int         RD_LAT    = 2,
   parameter int         SETUP_CYC = 3,
   parameter int         OE_CYC    = 2,
   parameter logic [1:0] ADDR_RD   = 2'b11
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              enable,
   input  logic              DATA_DIR,
   input  logic              FLAGA,
   input  logic              FLAGB,
   input  logic [DATA_W-1:0] DQ,
   input  logic              sink_afull,
   output logic              SLCS,
   output logic              SLOE,
   output logic              SLRD,
   output logic              SLWR,
   output logic [1:0]        A,
   output logic [DATA_W-1:0] m_data,
   output logic              m_valid,
   output logic              burst_done,
   output logic [12:0]       burst_words,
   output logic [31:0]       total_words,
   output logic [2:0]        state
);

   typedef enum logic [2:0] {
      S_IDLE  = 3'd0,
      S_ADDR  = 3'd1,
      S_WAIT  = 3'd2,
      S_OE    = 3'd3,
      S_READ  = 3'd4,
      S_DRAIN = 3'd5,
      S_DONE  = 3'd6
   } state_t;

   localparam logic [12:0] BURST_LEN_C = 13'(BURST_LEN);
   localparam logic [2:0]  SETUP_LAST  = 3'(SETUP_CYC - 1);
   localparam logic [2:0]  OE_LAST     = 3'(OE_CYC - 1);
   localparam logic [2:0]  DRAIN_LAST  = 3'(RD_LAT - 1);

   state_t              r_state, w_nextState;
   logic [2:0]          r_phaseCnt;
   logic [12:0]         r_issued;
   logic [12:0]         r_burstWords;
   logic                r_flagb;
   logic                r_slcs, r_sloe, r_slrd, r_done;
   logic [1:0]          r_a;
   logic [RD_LAT-1:0]   r_pipe;
   logic [DATA_W-1:0]   r_mData;
   logic                r_mValid;
   logic [31:0]         r_totalWords;
   logic                w_slcs, w_sloe, w_slrd, w_done, w_strobe;
   logic [1:0]          w_a;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state      <= S_IDLE;
         r_phaseCnt   <= 3'd0;
         r_issued     <= 13'd0;
         r_burstWords <= 13'd0;
         r_flagb      <= 1'b1;
         r_slcs       <= 1'b1;
         r_sloe       <= 1'b1;
         r_slrd       <= 1'b1;
         r_done       <= 1'b0;
         r_a          <= ADDR_RD;
      end else begin
         r_state    <= w_nextState;
         r_phaseCnt <= (w_nextState == r_state) ? r_phaseCnt + 3'd1 : 3'd0;
         r_flagb    <= FLAGB;
         if (w_strobe) begin
            r_issued <= r_issued + 13'd1;
         end else if (w_nextState == S_DONE) begin
            r_burstWords <= r_issued;
            r_issued     <= 13'd0;
         end
         r_slcs <= w_slcs;
         r_sloe <= w_sloe;
         r_slrd <= w_slrd;
         r_done <= w_done;
         r_a    <= w_a;
      end
   end

   // r_issued already counts the strobe on the bus this cycle, so hitting BURST_LEN means the last one is out.
   always_comb begin
      w_nextState = r_state;
      case (r_state)
         S_IDLE:  if (!DATA_DIR && enable) w_nextState = S_ADDR;
         S_ADDR:  if (r_phaseCnt == SETUP_LAST) w_nextState = S_WAIT;
         S_WAIT:  if (FLAGA && !sink_afull) w_nextState = S_OE;
         S_OE:    if (r_phaseCnt == OE_LAST) w_nextState = S_READ;
         S_READ:  if ((r_issued == BURST_LEN_C) || !r_flagb) w_nextState = S_DRAIN;
         S_DRAIN: if (r_phaseCnt == DRAIN_LAST) w_nextState = S_DONE;
         S_DONE:  w_nextState = S_IDLE;
         default: w_nextState = S_IDLE;
      endcase
   end

   // Decoded from the next state so the registered strobes line up with the state they belong to.
   always_comb begin
      w_slcs   = 1'b1;
      w_sloe   = 1'b1;
      w_slrd   = 1'b1;
      w_done   = 1'b0;
      w_strobe = 1'b0;
      w_a      = ADDR_RD;
      case (w_nextState)
         S_IDLE:  if (DATA_DIR) w_a = 2'b00;
         S_ADDR,
         S_WAIT:  w_slcs = 1'b0;
         S_OE,
         S_DRAIN: begin
            w_slcs = 1'b0;
            w_sloe = 1'b0;
         end
         S_READ: begin
            w_slcs   = 1'b0;
            w_sloe   = 1'b0;
            w_strobe = r_flagb && (r_issued != BURST_LEN_C);
            w_slrd   = ~w_strobe;
         end
         S_DONE:  w_done = 1'b1;
         default: w_done = 1'b0;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_pipe       <= '0;
         r_mData      <= '0;
         r_mValid     <= 1'b0;
         r_totalWords <= 32'd0;
      end else begin
         r_pipe[0] <= w_strobe;
         for (int i = 1; i < RD_LAT; i++) begin
            r_pipe[i] <= r_pipe[i-1];
         end
         r_mValid <= r_pipe[RD_LAT-1];
         if (r_pipe[RD_LAT-1]) begin
            r_mData      <= DQ;
            r_totalWords <= r_totalWords + 32'd1;
         end
      end
   end

   assign SLCS        = r_slcs;
   assign SLOE        = r_sloe;
   assign SLRD        = r_slrd;
   assign SLWR        = 1'b1;
   assign A           = r_a;
   assign m_data      = r_mData;
   assign m_valid     = r_mValid;
   assign burst_done  = r_done;
   assign burst_words = r_burstWords;
   assign total_words = r_totalWords;
   assign state       = r_state;

endmodule

// File: tb/tb_fx3_slave_fifo_rd_engine.sv
// Directed bench for the FX3 read engine: an FX3 socket model feeds DQ and a
// scoreboard queue, a monitor pops it on every m_valid.
module tb_fx3_slave_fifo_rd_engine;

   localparam int         DATA_W    = 32;
   localparam int         BURST_LEN = 8;
   localparam int         RD_LAT    = 2;
   localparam logic [2:0] ST_IDLE   = 3'd0;
   localparam logic [2:0] ST_ADDR   = 3'd1;
   localparam logic [2:0] ST_WAIT   = 3'd2;
   localparam logic [2:0] ST_OE     = 3'd3;
   localparam logic [2:0] ST_READ   = 3'd4;
   localparam logic [2:0] ST_DRAIN  = 3'd5;
   localparam logic [2:0] ST_DONE   = 3'd6;

   logic              clk = 1'b0;
   logic              rst_n;
   logic              enable, DATA_DIR, FLAGA, FLAGB, sink_afull;
   logic [DATA_W-1:0] DQ = '0;
   logic              SLCS, SLOE, SLRD, SLWR;
   logic [1:0]        A;
   logic [DATA_W-1:0] m_data;
   logic              m_valid, burst_done;
   logic [12:0]       burst_words;
   logic [31:0]       total_words;
   logic [2:0]        state;

   int                testCount = 0;
   int                failCount = 0;
   int                cycle = 0;
   int                strobeCount = 0;
   int                capCount = 0;
   logic [31:0]       nextWord = 32'h100;
   logic              strobePrev = 1'b0;
   logic [31:0]       sbQueue[$];

   fx3_slave_fifo_rd_engine #(
      .DATA_W(DATA_W), .BURST_LEN(BURST_LEN), .RD_LAT(RD_LAT),
      .SETUP_CYC(3), .OE_CYC(2), .ADDR_RD(2'b11)
   ) dut (
      .clk(clk), .rst_n(rst_n), .enable(enable), .DATA_DIR(DATA_DIR),
      .FLAGA(FLAGA), .FLAGB(FLAGB), .DQ(DQ), .sink_afull(sink_afull),
      .SLCS(SLCS), .SLOE(SLOE), .SLRD(SLRD), .SLWR(SLWR), .A(A),
      .m_data(m_data), .m_valid(m_valid), .burst_done(burst_done),
      .burst_words(burst_words), .total_words(total_words), .state(state)
   );

   always #5 clk = ~clk;

   always @(posedge clk) cycle++;

   task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
      testCount++;
      assert (observed === expected) else begin
         failCount++;
         $error("[TB] FAIL %s: observed %0h expected %0h", tag, observed, expected);
      end
   endtask

   task automatic applyStimulus(input logic en, input logic dir, input logic fa, input logic fb, input logic afull);
      enable     = en;
      DATA_DIR   = dir;
      FLAGA      = fa;
      FLAGB      = fb;
      sink_afull = afull;
   endtask

   task automatic waitState(input logic [2:0] target, input int budget, input string tag);
      int n = 0;
      while (state !== target && n < budget) begin
         @(negedge clk);
         n++;
      end
      checkOutput(tag, 32'(state), 32'(target));
   endtask

   task automatic waitDone(input int budget, input string tag);
      int n = 0;
      while (burst_done !== 1'b1 && n < budget) begin
         @(negedge clk);
         n++;
      end
      checkOutput(tag, 32'(burst_done), 32'd1);
   endtask

   task automatic waitStrobes(input int count, input int budget, input string tag);
      int n = 0;
      int seen = 0;
      while (seen < count && n < budget) begin
         @(negedge clk);
         n++;
         if (SLRD === 1'b0) seen++;
      end
      checkOutput(tag, 32'(seen), 32'(count));
   endtask

   // Socket model for RD_LAT=2: a strobe seen in one cycle puts its word on DQ the next cycle.
   always @(negedge clk) begin
      if (strobePrev && rst_n) begin
         DQ = nextWord;
         sbQueue.push_back(nextWord);
         nextWord++;
      end
      if (rst_n && SLRD === 1'b0) strobeCount++;
      strobePrev = rst_n && (SLRD === 1'b0);
   end

   always @(negedge clk) begin
      if (rst_n && m_valid === 1'b1) begin
         capCount++;
         checkOutput("sb_pending", 32'(sbQueue.size() > 0), 32'd1);
         if (sbQueue.size() > 0) checkOutput("sb_data", m_data, sbQueue.pop_front());
      end
   end

   initial begin
      #400000;
      $display("[TB] FAIL watchdog: simulation time limit reached");
      $fatal(1, "[TB] watchdog");
   end

   initial begin
      int n;
      int firstStrobe;
      int firstValid;
      int strStart;
      int capStart;

      rst_n = 1'b0;
      applyStimulus(1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
      repeat (2) @(negedge clk);
      checkOutput("rst_strobes", 32'({SLCS, SLOE, SLRD, SLWR}), 32'hF);
      checkOutput("rst_addr", 32'(A), 32'd3);
      checkOutput("rst_valid", 32'(m_valid), 32'd0);
      checkOutput("rst_state", 32'(state), 32'(ST_IDLE));
      checkOutput("rst_total", total_words, 32'd0);
      checkOutput("rst_bwords", 32'(burst_words), 32'd0);
      rst_n = 1'b1;
      @(negedge clk);

      // Full burst with latency check
      applyStimulus(1'b1, 1'b0, 1'b1, 1'b1, 1'b0);
      waitState(ST_ADDR, 5, "t1_addr");
      applyStimulus(1'b0, 1'b0, 1'b1, 1'b1, 1'b0);
      firstStrobe = -1;
      firstValid  = -1;
      strStart    = strobeCount;
      capStart    = capCount;
      n = 0;
      while (burst_done !== 1'b1 && n < 100) begin
         if (SLRD === 1'b0 && firstStrobe < 0) firstStrobe = cycle;
         if (m_valid === 1'b1 && firstValid < 0) firstValid = cycle;
         @(negedge clk);
         n++;
      end
      checkOutput("t1_done", 32'(burst_done), 32'd1);
      checkOutput("t1_bwords", 32'(burst_words), 32'd8);
      checkOutput("t1_strobes", 32'(strobeCount - strStart), 32'd8);
      checkOutput("t1_captured", 32'(capCount - capStart), 32'd8);
      checkOutput("t1_latency", 32'(firstValid - firstStrobe), 32'd2);
      checkOutput("t1_total", total_words, 32'd8);
      checkOutput("t1_sb_empty", 32'(sbQueue.size()), 32'd0);
      @(negedge clk);
      checkOutput("t1_pulse", 32'(burst_done), 32'd0);
      checkOutput("t1_idle", 32'(state), 32'(ST_IDLE));

      // FLAGA low holds the engine in WAIT
      applyStimulus(1'b1, 1'b0, 1'b0, 1'b1, 1'b0);
      waitState(ST_ADDR, 5, "t2_addr");
      applyStimulus(1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
      waitState(ST_WAIT, 10, "t2_wait");
      for (int i = 0; i < 20; i++) begin
         @(negedge clk);
         checkOutput("t2_hold", 32'({state, SLOE, SLRD}), 32'({ST_WAIT, 2'b11}));
      end
      applyStimulus(1'b0, 1'b0, 1'b1, 1'b1, 1'b0);
      @(negedge clk);
      checkOutput("t2_sloe", 32'(SLOE), 32'd0);
      checkOutput("t2_oe", 32'(state), 32'(ST_OE));
      waitDone(50, "t2_done");
      checkOutput("t2_bwords", 32'(burst_words), 32'd8);
      checkOutput("t2_total", total_words, 32'd16);
      @(negedge clk);

      // FLAGB drops after the third strobe: one more strobe slips out
      applyStimulus(1'b1, 1'b0, 1'b1, 1'b1, 1'b0);
      waitState(ST_ADDR, 5, "t3_addr");
      applyStimulus(1'b0, 1'b0, 1'b1, 1'b1, 1'b0);
      capStart = capCount;
      waitStrobes(3, 50, "t3_three");
      applyStimulus(1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
      @(negedge clk);
      checkOutput("t3_fourth", 32'({state, SLRD}), 32'({ST_READ, 1'b0}));
      @(negedge clk);
      checkOutput("t3_drain1", 32'({state, SLRD}), 32'({ST_DRAIN, 1'b1}));
      @(negedge clk);
      checkOutput("t3_drain2", 32'(state), 32'(ST_DRAIN));
      @(negedge clk);
      checkOutput("t3_done", 32'({state, burst_done}), 32'({ST_DONE, 1'b1}));
      checkOutput("t3_bwords", 32'(burst_words), 32'd4);
      checkOutput("t3_captured", 32'(capCount - capStart), 32'd4);
      checkOutput("t3_total", total_words, 32'd20);
      applyStimulus(1'b0, 1'b0, 1'b1, 1'b1, 1'b0);
      @(negedge clk);

      // Sink back-pressure in WAIT
      applyStimulus(1'b1, 1'b0, 1'b1, 1'b1, 1'b1);
      waitState(ST_ADDR, 5, "t4_addr");
      applyStimulus(1'b0, 1'b0, 1'b1, 1'b1, 1'b1);
      waitState(ST_WAIT, 10, "t4_wait");
      for (int i = 0; i < 5; i++) begin
         @(negedge clk);
         checkOutput("t4_hold", 32'({state, SLOE}), 32'({ST_WAIT, 1'b1}));
      end
      applyStimulus(1'b0, 1'b0, 1'b1, 1'b1, 1'b0);
      @(negedge clk);
      checkOutput("t4_sloe", 32'({state, SLOE}), 32'({ST_OE, 1'b0}));
      waitDone(50, "t4_done");
      checkOutput("t4_bwords", 32'(burst_words), 32'd8);
      checkOutput("t4_total", total_words, 32'd28);
      @(negedge clk);

      // Asynchronous reset at the fifth strobe, then a fresh burst
      applyStimulus(1'b1, 1'b0, 1'b1, 1'b1, 1'b0);
      waitState(ST_ADDR, 5, "t5_addr");
      waitStrobes(5, 50, "t5_five");
      rst_n = 1'b0;
      #1;
      checkOutput("t5_strobes", 32'({SLCS, SLOE, SLRD, SLWR}), 32'hF);
      checkOutput("t5_valid", 32'(m_valid), 32'd0);
      checkOutput("t5_total", total_words, 32'd0);
      checkOutput("t5_bwords", 32'(burst_words), 32'd0);
      checkOutput("t5_state", 32'(state), 32'(ST_IDLE));
      sbQueue.delete();
      repeat (2) @(negedge clk);
      sbQueue.delete();
      rst_n = 1'b1;
      waitState(ST_ADDR, 5, "t5_restart");
      applyStimulus(1'b0, 1'b0, 1'b1, 1'b1, 1'b0);
      waitDone(50, "t5_done");
      checkOutput("t5_bwords2", 32'(burst_words), 32'd8);
      checkOutput("t5_total2", total_words, 32'd8);
      @(negedge clk);

      // Counter wrap and DATA_DIR parking mid-burst
      force dut.r_totalWords = 32'hFFFF_FFFE;
      #1;
      release dut.r_totalWords;
      checkOutput("t6_preload", total_words, 32'hFFFF_FFFE);
      applyStimulus(1'b1, 1'b0, 1'b1, 1'b1, 1'b0);
      waitState(ST_ADDR, 5, "t6_addr");
      applyStimulus(1'b0, 1'b0, 1'b1, 1'b1, 1'b0);
      waitStrobes(2, 50, "t6_two");
      applyStimulus(1'b0, 1'b1, 1'b1, 1'b1, 1'b0);
      waitDone(50, "t6_done");
      checkOutput("t6_bwords", 32'(burst_words), 32'd8);
      checkOutput("t6_total", total_words, 32'd6);
      @(negedge clk);
      checkOutput("t6_park", 32'({state, A}), 32'({ST_IDLE, 2'b00}));
      applyStimulus(1'b1, 1'b1, 1'b1, 1'b1, 1'b0);
      repeat (10) @(negedge clk);
      checkOutput("t6_stay", 32'({state, A, SLCS}), 32'({ST_IDLE, 2'b00, 1'b1}));
      applyStimulus(1'b0, 1'b0, 1'b1, 1'b1, 1'b0);
      @(negedge clk);
      checkOutput("t6_unpark", 32'(A), 32'd3);

      $display("[TB] %0d tests run, %0d failed", testCount, failCount);
      $finish;
   end

endmodule
